// File: rtl/npu_layer_seq.sv
// rtl/npu_layer_seq.sv - per-layer start/done sequencer with abort and watchdog
module npu_layer_seq #(
    parameter int NL       = 2,
    parameter int CLOG2NL  = 1,
    parameter int GAP      = 2,
    parameter int TMO      = 65535,
    parameter int CLOG2TMO = 16
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               i_run_valid,
    output logic               o_run_ready,
    input  logic [CLOG2NL:0]   i_run_nl,
    input  logic               i_abort,
    output logic               o_start,
    input  logic               i_done,
    output logic [CLOG2NL-1:0] o_layer_sel,
    output logic               o_c1_c2_n,
    output logic               o_bank_sel,
    output logic               o_busy,
    output logic               o_run_done,
    output logic               o_err,
    output logic               o_abrt
);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CLOG2NL:0]    NL_MAX   = (CLOG2NL + 1)'(NL);
    localparam logic [CLOG2NL:0]    NL_ONE   = (CLOG2NL + 1)'(1);
    localparam logic [CLOG2NL-1:0]  LS_ONE   = CLOG2NL'(1);
    localparam logic [GW-1:0]       GAP_LD   = GW'(GAP - 1);
    localparam logic [GW-1:0]       GAP_ONE  = GW'(1);
    localparam logic [CLOG2TMO-1:0] TMO_LAST = CLOG2TMO'(TMO - 1);
    localparam logic [CLOG2TMO-1:0] TMO_ONE  = CLOG2TMO'(1);

    typedef enum logic [2:0] {IDLE, SETUP, KICK, RUN, NEXT, FIN} state_t;

    state_t              state;
    logic                done_d;
    logic                abort_pend;
    logic [CLOG2NL:0]    nl_r;
    logic [GW-1:0]       gap_cnt;
    logic [CLOG2TMO-1:0] tmo_cnt;
    logic                done_rise;
    logic                last_layer;

    assign done_rise  = i_done & ~done_d;
    assign last_layer = ({1'b0, o_layer_sel} == (nl_r - NL_ONE));

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            done_d      <= 1'b0;
            abort_pend  <= 1'b0;
            nl_r        <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            o_run_ready <= 1'b1;
            o_start     <= 1'b0;
            o_layer_sel <= '0;
            o_c1_c2_n   <= 1'b0;
            o_bank_sel  <= 1'b0;
            o_busy      <= 1'b0;
            o_run_done  <= 1'b0;
            o_err       <= 1'b0;
            o_abrt      <= 1'b0;
        end else begin
            done_d     <= i_done;
            o_start    <= 1'b0;
            o_run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_run_valid) begin
                        nl_r        <= (i_run_nl > NL_MAX) ? NL_MAX : i_run_nl;
                        o_err       <= 1'b0;
                        o_abrt      <= 1'b0;
                        o_layer_sel <= '0;
                        o_c1_c2_n   <= 1'b0;
                        o_bank_sel  <= 1'b0;
                        o_run_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        if (i_run_nl == '0) begin
                            state      <= FIN;
                            o_run_done <= 1'b1;
                        end else begin
                            state   <= SETUP;
                            gap_cnt <= GAP_LD;
                        end
                    end
                end
                SETUP: begin
                    if (i_abort) begin
                        o_abrt     <= 1'b1;
                        state      <= FIN;
                        o_run_done <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        state   <= KICK;
                        o_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                KICK: begin
                    tmo_cnt    <= '0;
                    abort_pend <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    // completion is checked before the watchdog so a tie never flags an error
                    if (done_rise) begin
                        if (abort_pend || i_abort) begin
                            o_abrt     <= 1'b1;
                            state      <= FIN;
                            o_run_done <= 1'b1;
                        end else if (last_layer) begin
                            state      <= FIN;
                            o_run_done <= 1'b1;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        if (i_abort) abort_pend <= 1'b1;
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                        if (TMO != 0 && tmo_cnt == TMO_LAST) begin
                            o_err      <= 1'b1;
                            state      <= FIN;
                            o_run_done <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    o_layer_sel <= o_layer_sel + LS_ONE;
                    o_c1_c2_n   <= 1'b1;
                    o_bank_sel  <= ~o_bank_sel;
                    gap_cnt     <= GAP_LD;
                    state       <= SETUP;
                end
                FIN: begin
                    state       <= IDLE;
                    o_run_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    o_run_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/npu_layer_seq.md
# npu_layer_seq

Layer sequencer for the NPU: accepts a run command for N convolution layers and, per layer, selects the layer configuration for `ctrl_param`, selects the activation bank polarity, pulses `start` into `fsm`, and waits for `done` before advancing. Replaces the manual start/done/reconfigure sequence between layers. Also handles abort and watchdog timeout. Sits between the host/command interface and the `fsm` + `ctrl_param` pair.

## Interface
- `NL`, 2: maximum layers per run.
- `CLOG2NL`, 1: width of the layer index.
- `GAP`, 2: settle cycles, ≥1. Configuration is held stable for these cycles before each start.
- `TMO`, 65535: watchdog limit in cycles per layer. 0 disables the watchdog.
- `CLOG2TMO`, 16: width of the watchdog counter.

Ports (clock and reset first):
- `ck`  in  1  clock. Single clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_run_valid`  in  1  run command valid.
- `o_run_ready`  out  1  ready to accept a command. High only in IDLE.
- `i_run_nl`  in  CLOG2NL+1  number of layers; sampled on accept.
- `i_abort`  in  1  abort request (level).
- `o_start`  out  1  one-cycle start pulse to `fsm`.
- `i_done`  in  1  `fsm` done; a rising edge marks layer completion.
- `o_layer_sel`  out  CLOG2NL  index of the current layer.
- `o_c1_c2_n`  out  1  layer select to `ctrl_param`: 0 for layer 0, 1 otherwise.
- `o_bank_sel`  out  1  activation bank polarity: 0 = bank A in/bank B out, 1 = swapped.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_run_done`  out  1  one-cycle pulse when a run ends.
- `o_err`  out  1  sticky watchdog error; cleared on the next accept.
- `o_abrt`  out  1  sticky aborted flag; cleared on the next accept.

## Operation
- **States:** IDLE, SETUP, KICK, RUN, NEXT, FIN.
- **Reset values:** state IDLE; all outputs 0 except `o_run_ready`, which is 1. Internal state also resets: `done_d`=0, `nl_r`=0, `gap_cnt`=0, `tmo_cnt`=0, `abort_pend`=0.
- **Reset mid-run:** takes effect immediately. `o_start` drops within the same cycle and no pending state survives.
- **Command accept:** occurs when `i_run_valid` & `o_run_ready`.
  - Latch `nl_r` = min(`i_run_nl`, `NL`).
  - Clear `o_err`, `o_abrt`, `o_layer_sel` and `o_bank_sel`.
  - If `nl_r`==0, go to FIN; otherwise go to SETUP with `gap_cnt`=`GAP`-1.
- **SETUP:**
  - If `i_abort`, set `o_abrt` and go to FIN.
  - Otherwise decrement `gap_cnt`; at 0, go to KICK.
- **KICK:**
  - Drive `o_start`=1 for exactly this cycle.
  - Clear `tmo_cnt` and `abort_pend`, then go to RUN.
- **RUN:**
  - `done_rise` = `i_done` & ~`done_d`. `done_d` is a register sampled every cycle.
  - `i_abort` sets `abort_pend`. The layer in flight is never cut short.
  - On `done_rise`:
    - If `abort_pend` or `i_abort`, set `o_abrt` and go to FIN.
    - Else if `o_layer_sel`==`nl_r`-1, go to FIN.
    - Else go to NEXT.
  - Otherwise `tmo_cnt`++. If `TMO`≠0 and `tmo_cnt`==`TMO`-1, set `o_err` and go to FIN.
- **NEXT:** `o_layer_sel`++, toggle `o_bank_sel`, load `gap_cnt`=`GAP`-1, go to SETUP.
- **FIN:** `o_run_done`=1 for one cycle, then go to IDLE.
- **Held outputs:** `o_layer_sel` and `o_bank_sel` hold their values after the run ends, until the next accept.
- **Ignored inputs:** `done_rise` outside RUN is ignored. A `done` already high at KICK does not count; a fresh rising edge is required.
- **Simultaneous events:** `done_rise` and watchdog expiry in the same cycle: done wins, no error.

## Timing
- Accept at edge T:
  - SETUP in cycles T+1..T+`GAP`.
  - `o_start` high in cycle T+`GAP`+1.
- `done_rise` seen in cycle D, more layers remain:
  - NEXT at D+1.
  - `o_start` at D+`GAP`+2.
  - `o_layer_sel` and `o_bank_sel` change at D+2 and are stable for ≥`GAP` cycles before `o_start`.
- `done_rise` seen in cycle D, last layer: `o_run_done` at D+1, `o_run_ready` at D+2.
- `nl_r`==0: `o_run_done` at T+1, `o_run_ready` at T+2, no `o_start`.
- Watchdog: expiry at RUN cycle `TMO`, then `o_run_done` the next cycle.

## Test plan
- **Two-layer run.** Reset, then `i_run_nl`=2 with `GAP`=2; bench `fsm` model raises `done` 50 cycles after each start.
  - Exactly 2 `o_start` pulses.
  - Layer 0 runs with `o_c1_c2_n`=0, `o_bank_sel`=0; layer 1 with `o_c1_c2_n`=1, `o_bank_sel`=1.
  - Second start occurs 4 cycles after the first `done` rise.
  - One `o_run_done`; `o_err`=`o_abrt`=0.
- **Zero layers.** `i_run_nl`=0 → no `o_start`; `o_run_done` 1 cycle after accept.
- **Clamp.** `i_run_nl`=3 with `NL`=2 → exactly 2 starts.
- **Abort during layer 0 RUN.** Pulse `i_abort` for 1 cycle → no second `o_start`; `o_run_done` 1 cycle after the `done` rise; `o_abrt`=1.
  - Next accept clears `o_abrt`.
- **Watchdog.** `TMO`=16, `done` never rises → `o_err`=1; `o_run_done` at 17 cycles after KICK; `o_run_ready` returns high.
- **Reset and stale done.**
  - Async reset asserted mid-SETUP and mid-RUN → all outputs take reset values immediately.
  - `i_done` held high from KICK → no false completion until it falls and rises again.
  - A `done` rise in the same cycle as watchdog expiry → `o_err`=0.
